sig_seq_producer: RTL and testbench
===================================

Name: sig_seq_producer

Overview:
- Upstream stage that drives the 3-bit `some_sig` bus read by the downstream consumer in the same top.
- Accepts timed commands over a valid/ready interface and buffers them in a small FIFO.
- Plays each command's value onto `some_sig` for a programmed number of cycles, then returns the bus to an idle value.
- Sole driver of `some_sig`; the top may also export it as a port.

Parameters:
- WIDTH, 3, width of `some_sig` and `cmd_val`
- CNT_W, 8, width of the hold count
- DEPTH, 4, command FIFO depth; power of 2, ≥2
- IDLE_VAL, 3'd0, value driven on `some_sig` when no command is playing

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept a command
- cmd_val  input  WIDTH  value to drive
- cmd_hold  input  CNT_W  extra hold cycles; value shown for `cmd_hold`+1 cycles
- flush  input  1  synchronous abort: drop queue and current command
- some_sig  output  WIDTH  registered produced signal
- sig_active  output  1  registered; 1 while a command is playing
- sig_strobe  output  1  registered; 1 on the first cycle of each new command
- fifo_level  output  $clog2(DEPTH)+1  entries currently queued

Behaviour:
- Reset (`rst`=1 at an edge) sets outputs to:
  - `some_sig`=IDLE_VAL
  - `sig_active`=0, `sig_strobe`=0
  - `fifo_level`=0, FIFO pointers 0
  - FSM=IDLE, hold counter=0
- `cmd_ready` = !rst && !flush && (`fifo_level` != DEPTH). It is combinational from state and these two inputs only, never from `cmd_valid`.
- Push: a command is written when `cmd_valid` && `cmd_ready` at an edge.
- When full, no push is accepted, even if a pop happens in the same cycle.
- Pointers carry one extra wrap bit: full = MSBs differ and lower bits equal.
- `fifo_level` accounts for push and pop in the same cycle (net unchanged).
- FSM IDLE:
  - If `fifo_level`>0 at the edge: pop head, `some_sig`<=head.val, counter<=head.hold, `sig_strobe`<=1, `sig_active`<=1, go to HOLD.
  - Otherwise `some_sig` stays IDLE_VAL and `sig_strobe`<=0.
- FSM HOLD:
  - `sig_strobe`<=0 unless reloading.
  - If counter≠0: counter<=counter−1.
  - If counter==0 and FIFO non-empty: pop and load the next command back-to-back (no idle gap, `sig_strobe`<=1).
  - If counter==0 and FIFO empty: `some_sig`<=IDLE_VAL, `sig_active`<=0, go to IDLE.
- Latency:
  - A command accepted at edge E into an empty FIFO with FSM IDLE drives `some_sig` from edge E+1.
  - There is no same-cycle bypass.
  - Each value is held exactly `cmd_hold`+1 cycles; `cmd_hold`=0 gives a 1-cycle pulse.
  - `cmd_hold`=2^CNT_W−1 holds for 2^CNT_W cycles with no counter wrap.
- Flush (`flush`=1 at an edge):
  - Takes effect at the next edge: pointers cleared, `fifo_level`=0, FSM=IDLE, `some_sig`=IDLE_VAL, `sig_active`=0, `sig_strobe`=0.
  - Any push presented in that cycle is dropped, since `cmd_ready`=0.
- Priority: rst > flush > normal operation.
- Reset or flush mid-hold abandons the current value immediately; nothing is replayed.
- FIFO storage is not reset; only pointers and control are.

Optional Feature:
- Macro: `SIG_SEQ_PRODUCER_PARITY_EN`.
- When defined:
  - Adds output `some_sig_par` (1 bit, registered) = even parity (XOR) of the `some_sig` value loaded in the same cycle.
  - Reset/flush/idle value = ^IDLE_VAL.
  - Updated in lock-step with `some_sig`.
- When undefined, the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then idle 5 cycles → `some_sig`=0, `sig_active`=0, `cmd_ready`=1, `fifo_level`=0.
- Push (val=5, hold=2) at edge E into empty FIFO → `some_sig`=5 for edges E+1..E+3 with `sig_strobe`=1 only at E+1; `some_sig`=0 and `sig_active`=0 at E+4.
- Push 4 commands (1/0, 2/0, 3/1, 4/0) back-to-back with FSM busy → FIFO full, `cmd_ready`=0 while `fifo_level`=4; output sequence 1,2,3,3,4 with no idle gaps and a strobe on each new value.
- With `fifo_level`=4 and a pop occurring, hold `cmd_valid`=1 → push is not accepted that cycle; it is accepted the next cycle when `fifo_level`=3.
- Assert `flush` mid-hold of val=6 (hold=10) with 2 queued → next edge `some_sig`=0, `fifo_level`=0, `sig_active`=0; the concurrent push is dropped.
- `SIG_SEQ_PRODUCER_PARITY_EN` defined, play val=3 then val=7 → `some_sig_par`=0 then 1, aligned with `some_sig`; 0 after return to idle.

Source files
------------

// File: rtl/sig_seq_producer.sv
// sig_seq_producer: sole driver of the some_sig bus.
// Timed commands (value, hold) arrive over valid/ready into a small FIFO
// and are played onto some_sig for hold+1 cycles each, back-to-back when
// queued, returning to IDLE_VAL when the queue drains.
// Optional macro SIG_SEQ_PRODUCER_PARITY_EN adds registered even-parity
// output some_sig_par that tracks some_sig.
module sig_seq_producer #(
  parameter int               WIDTH    = 3,
  parameter int               CNT_W    = 8,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [WIDTH-1:0]         cmd_val,
  input  logic [CNT_W-1:0]         cmd_hold,
  input  logic                     flush,
  output logic [WIDTH-1:0]         some_sig,
`ifdef SIG_SEQ_PRODUCER_PARITY_EN
  output logic                     some_sig_par,
`endif
  output logic                     sig_active,
  output logic                     sig_strobe,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  function automatic logic even_par(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Command storage holds data only; it is never reset.
  logic [WIDTH-1:0] val_mem  [DEPTH];
  logic [CNT_W-1:0] hold_mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] some_sig_q, some_sig_d;
  logic             active_q, active_d;
  logic             strobe_q, strobe_d;
  logic             par_q, par_d;

  logic             fifo_empty, fifo_full, push, pop;
  logic [WIDTH-1:0] head_val;
  logic [CNT_W-1:0] head_hold;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_level = wr_ptr_q - rd_ptr_q;

  // Ready never looks at cmd_valid; a full FIFO refuses even while popping.
  assign cmd_ready  = !rst && !flush && !fifo_full;
  assign push       = cmd_valid && cmd_ready;

  assign head_val   = val_mem[rd_ptr_q[AW-1:0]];
  assign head_hold  = hold_mem[rd_ptr_q[AW-1:0]];

  // Next-state for the playback FSM, FIFO pointers and registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    some_sig_d = some_sig_q;
    active_d   = active_q;
    strobe_d   = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          some_sig_d = head_val;
          cnt_d      = head_hold;
          strobe_d   = 1'b1;
          active_d   = 1'b1;
          state_d    = S_HOLD;
        end else begin
          some_sig_d = IDLE_VAL;
          active_d   = 1'b0;
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!fifo_empty) begin
          // Reload straight from the queue so there is no idle gap.
          pop        = 1'b1;
          some_sig_d = head_val;
          cnt_d      = head_hold;
          strobe_d   = 1'b1;
        end else begin
          some_sig_d = IDLE_VAL;
          active_d   = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        some_sig_d = IDLE_VAL;
        active_d   = 1'b0;
      end
    endcase
    // Flush abandons the current command and the whole queue.
    if (flush) begin
      pop        = 1'b0;
      state_d    = S_IDLE;
      cnt_d      = '0;
      some_sig_d = IDLE_VAL;
      active_d   = 1'b0;
      strobe_d   = 1'b0;
    end
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    par_d    = even_par(some_sig_d);
  end

  // Control and output registers; reset has priority over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      some_sig_q <= IDLE_VAL;
      active_q   <= 1'b0;
      strobe_q   <= 1'b0;
      par_q      <= even_par(IDLE_VAL);
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      some_sig_q <= some_sig_d;
      active_q   <= active_d;
      strobe_q   <= strobe_d;
      par_q      <= par_d;
    end
  end

  // FIFO write port.
  always_ff @(posedge clk) begin
    if (push) begin
      val_mem[wr_ptr_q[AW-1:0]]  <= cmd_val;
      hold_mem[wr_ptr_q[AW-1:0]] <= cmd_hold;
    end
  end

  assign some_sig   = some_sig_q;
  assign sig_active = active_q;
  assign sig_strobe = strobe_q;

`ifdef SIG_SEQ_PRODUCER_PARITY_EN
  assign some_sig_par = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_sig_seq_producer.sv
// Scoreboard bench for sig_seq_producer: stimulus pushes the expected
// per-cycle (value, strobe) stream; a negedge monitor pops and compares.
module tb_sig_seq_producer;

  localparam int WIDTH = 3;
  localparam int CNT_W = 8;
  localparam int DEPTH = 4;
  localparam logic [WIDTH-1:0] IDLE_VAL = 3'd0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_val = '0;
  logic [CNT_W-1:0] cmd_hold = '0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] some_sig;
`ifdef SIG_SEQ_PRODUCER_PARITY_EN
  logic             some_sig_par;
`endif
  logic             sig_active;
  logic             sig_strobe;
  logic [2:0]       fifo_level;

  sig_seq_producer #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .DEPTH(DEPTH), .IDLE_VAL(IDLE_VAL)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_val(cmd_val), .cmd_hold(cmd_hold), .flush(flush),
    .some_sig(some_sig),
`ifdef SIG_SEQ_PRODUCER_PARITY_EN
    .some_sig_par(some_sig_par),
`endif
    .sig_active(sig_active), .sig_strobe(sig_strobe), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] val;
    logic             strb;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;
  logic mon_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: every active cycle consumes one expected (value, strobe) entry.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (sig_active) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_active", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sig_value", 32'(some_sig), 32'(mon_e.val));
          chk("sig_strobe", 32'(sig_strobe), 32'(mon_e.strb));
`ifdef SIG_SEQ_PRODUCER_PARITY_EN
          chk("sig_parity", 32'(some_sig_par), 32'(^mon_e.val));
`endif
        end
      end else begin
        chk("idle_value", 32'(some_sig), 32'(IDLE_VAL));
        chk("idle_strobe", 32'(sig_strobe), 0);
`ifdef SIG_SEQ_PRODUCER_PARITY_EN
        chk("idle_parity", 32'(some_sig_par), 32'(^IDLE_VAL));
`endif
      end
    end
  end

  task automatic exp_push(input logic [WIDTH-1:0] v, input logic [CNT_W-1:0] h);
    for (int i = 0; i <= int'(h); i++) exp_q.push_back('{val: v, strb: (i == 0)});
  endtask

  // Present one command and wait (bounded) until it is accepted.
  task automatic send(input logic [WIDTH-1:0] v, input logic [CNT_W-1:0] h);
    int n;
    cmd_valid = 1'b1;
    cmd_val   = v;
    cmd_hold  = h;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 200);
    if (!cmd_ready) chk("send_timeout", 1, 0);
    else exp_push(v, h);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sig_active || fifo_level != 0) && n < 600);
    chk("wait_idle_timeout", 32'(n >= 600), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic [2:0] lvl;

    // Reset phase.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_sig", 32'(some_sig), 0);
    chk("rst_active", 32'(sig_active), 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("idle_ready", 32'(cmd_ready), 1);
    chk("idle_level", 32'(fifo_level), 0);
    chk("idle_active", 32'(sig_active), 0);
    @(posedge clk);
    #1;

    // Single command, 3-cycle hold.
    send(3'd5, 8'd2);
    wait_idle();
    chk("single_drained", 32'(exp_q.size()), 0);

    // Fill the FIFO behind a long-running command.
    @(posedge clk);
    #1;
    send(3'd7, 8'd20);
    send(3'd1, 8'd0);
    send(3'd2, 8'd0);
    send(3'd3, 8'd1);
    send(3'd4, 8'd0);
    @(negedge clk);
    chk("full_level", 32'(fifo_level), 4);
    chk("full_ready", 32'(cmd_ready), 0);

    // Keep pushing while full: acceptance only once the level drops to 3.
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_val   = 3'd5;
    cmd_hold  = 8'd0;
    n = 0;
    do begin
      @(negedge clk);
      lvl = fifo_level;
      n++;
    end while (!cmd_ready && n < 200);
    chk("full_accept_level", 32'(lvl), 3);
    exp_push(3'd5, 8'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("push_pop_level", 32'(fifo_level), 3);
    wait_idle();
    chk("burst_drained", 32'(exp_q.size()), 0);

    // Flush mid-hold with two commands queued and a push presented.
    @(posedge clk);
    #1;
    send(3'd6, 8'd10);
    send(3'd1, 8'd0);
    send(3'd2, 8'd0);
    flush     = 1'b1;
    cmd_valid = 1'b1;
    cmd_val   = 3'd3;
    cmd_hold  = 8'd0;
    @(negedge clk);
    chk("flush_ready", 32'(cmd_ready), 0);
    chk("flush_pre_level", 32'(fifo_level), 2);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    cmd_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_sig", 32'(some_sig), 0);
    chk("flush_level", 32'(fifo_level), 0);
    chk("flush_active", 32'(sig_active), 0);
    repeat (3) @(negedge clk);
    chk("flush_push_dropped", 32'(fifo_level), 0);

    // Parity pair and maximum hold length.
    @(posedge clk);
    #1;
    send(3'd3, 8'd0);
    send(3'd7, 8'd0);
    wait_idle();
    @(posedge clk);
    #1;
    send(3'd1, 8'd255);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    chk("final_ready", 32'(cmd_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
